// File: rtl/calculation_unit_divider_core.sv
// Sequential restoring divider for float32 mantissas: one quotient bit per cycle,
// 26 quotient bits (hidden bit plus 25 fractional bits), sticky from the final remainder.
module calculation_unit_divider_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  exponent_a,
  input  logic [7:0]  exponent_b,
  input  logic [23:0] mantissa_a,
  input  logic [23:0] mantissa_b,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [25:0] quotient,
  output logic        sticky,
  output logic [9:0]  exponent_diff,
  output logic        div_by_zero,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for an operand set; start_ready high
  // DIVIDE | one restoring step per cycle, counter 0..25
  // DONE   | result held until result_ready
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] rem_q, rem_d;
  logic [23:0] div_q, div_d;
  logic [25:0] quot_q, quot_d;
  logic        sticky_q, sticky_d;
  logic [9:0]  expd_q, expd_d;
  logic        dbz_q, dbz_d;

  logic        rem_ge;
  logic [24:0] rem_sub;

  assign rem_ge  = (rem_q >= {1'b0, div_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quot_d   = quot_q;
    sticky_d = sticky_q;
    expd_d   = expd_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d  = ST_DIVIDE;
          cnt_d    = 5'd0;
          rem_d    = {1'b0, mantissa_a};
          div_d    = mantissa_b;
          quot_d   = 26'd0;
          sticky_d = 1'b0;
          expd_d   = {{2{exponent_a[7]}}, exponent_a} - {{2{exponent_b[7]}}, exponent_b};
          dbz_d    = (mantissa_b == 24'd0);
        end
      end
      ST_DIVIDE: begin
        quot_d = {quot_q[24:0], rem_ge};
        rem_d  = {rem_sub[23:0], 1'b0};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd25) begin
          state_d  = ST_DONE;
          sticky_d = |rem_d;
          // A zero divisor yields a saturated quotient with the usual latency
          if (dbz_q) begin
            quot_d   = 26'h3FFFFFF;
            sticky_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 25'd0;
      div_q    <= 24'd0;
      quot_q   <= 26'd0;
      sticky_q <= 1'b0;
      expd_q   <= 10'd0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quot_q   <= quot_d;
      sticky_q <= sticky_d;
      expd_q   <= expd_d;
      dbz_q    <= dbz_d;
    end
  end

  assign start_ready   = (state_q == ST_IDLE);
  assign result_valid  = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign quotient      = quot_q;
  assign sticky        = sticky_q;
  assign exponent_diff = expd_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_calculation_unit_divider_core.sv
// Self-checking bench for calculation_unit_divider_core: vector table, scoreboard,
// hold/reset/back-to-back sequences.
module tb_calculation_unit_divider_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  exponent_a, exponent_b;
  logic [23:0] mantissa_a, mantissa_b;
  logic        result_valid;
  logic        result_ready;
  logic [25:0] quotient;
  logic        sticky;
  logic [9:0]  exponent_diff;
  logic        div_by_zero;
  logic        busy;

  calculation_unit_divider_core dut (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .exponent_a(exponent_a), .exponent_b(exponent_b),
    .mantissa_a(mantissa_a), .mantissa_b(mantissa_b),
    .result_valid(result_valid), .result_ready(result_ready),
    .quotient(quotient), .sticky(sticky), .exponent_diff(exponent_diff),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [25:0] q;
    logic        s;
    logic [9:0]  ed;
    logic        dz;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: long division by integer arithmetic
  function automatic vec_t model(input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb);
    vec_t v;
    logic [63:0] num, qq, rr;
    int d;
    v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
    d = $signed(ea) - $signed(eb);
    v.ed = d[9:0];
    if (mb == 24'd0) begin
      v.q = 26'h3FFFFFF; v.s = 1'b1; v.dz = 1'b1;
    end else begin
      num = {40'd0, ma} << 25;
      qq = num / {40'd0, mb};
      rr = num % {40'd0, mb};
      v.q = qq[25:0]; v.s = (rr != 0); v.dz = 1'b0;
    end
    return v;
  endfunction

  task automatic compare_result(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_quotient"}, {6'd0, quotient}, {6'd0, e.q});
    chk({tag, "_sticky"}, {31'd0, sticky}, {31'd0, e.s});
    chk({tag, "_expdiff"}, {22'd0, exponent_diff}, {22'd0, e.ed});
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dz});
  endtask

  // Accept one operation, measure latency, compare, then consume the result
  task automatic do_op(input vec_t v, input string tag, output int wait_cycles);
    int lat;
    @(negedge clk);
    exponent_a = v.ea; exponent_b = v.eb; mantissa_a = v.ma; mantissa_b = v.mb;
    start_valid = 1'b1;
    wait_cycles = 0;
    while (!start_ready && wait_cycles < 100) begin
      @(negedge clk); wait_cycles++;
    end
    @(posedge clk);
    sb.push_back(v);
    #1 start_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, 32'd26);
    compare_result(tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({tag, "_back_idle"}, {30'd0, start_ready, result_valid}, 32'd2);
  endtask

  initial begin
    int w, n, accepts, last_acc, cyc;
    logic [25:0] hq; logic hs; logic [9:0] he; logic hd;
    logic chg;

    vecs[0] = '{ea:8'd3,  eb:8'd1,  ma:24'h800000, mb:24'h800000, q:26'h2000000, s:1'b0, ed:10'd2,   dz:1'b0};
    vecs[1] = '{ea:8'h80, eb:8'h7F, ma:24'h800000, mb:24'hC00000, q:26'h1555555, s:1'b1, ed:10'h301, dz:1'b0};
    vecs[2] = '{ea:8'd0,  eb:8'd0,  ma:24'hA00000, mb:24'h000000, q:26'h3FFFFFF, s:1'b1, ed:10'd0,   dz:1'b1};
    vecs[3] = '{ea:8'h7F, eb:8'h80, ma:24'hFFFFFF, mb:24'h800000, q:26'h3FFFFFC, s:1'b0, ed:10'h0FF, dz:1'b0};
    vecs[4] = '{ea:8'd0,  eb:8'd0,  ma:24'h800000, mb:24'hFFFFFF, q:26'h1000001, s:1'b1, ed:10'd0,   dz:1'b0};

    reset_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    exponent_a = 8'd0; exponent_b = 8'd0; mantissa_a = 24'd0; mantissa_b = 24'd0;
    #23;
    chk("rst_outputs", {quotient, sticky, div_by_zero, result_valid, busy, start_ready},
        {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("rst_expdiff", {22'd0, exponent_diff}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i), w);
      if (i == 0) chk("first_accept_wait", w, 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      vec_t r;
      r = model(8'($urandom), 8'($urandom), {1'b1, 23'($urandom)}, {1'b1, 23'($urandom)});
      do_op(r, $sformatf("rand%0d", i), w);
    end

    // Hold in DONE with result_ready low; start_valid pulses must be ignored
    @(negedge clk);
    exponent_a = 8'd5; exponent_b = 8'd2; mantissa_a = 24'hC00000; mantissa_b = 24'h900000;
    sb.push_back(model(8'd5, 8'd2, 24'hC00000, 24'h900000));
    start_valid = 1'b1;
    @(posedge clk); #1 start_valid = 1'b0;
    n = 0;
    while (!result_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold_latency", n, 32'd26);
    hq = quotient; hs = sticky; he = exponent_diff; hd = div_by_zero;
    compare_result("hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_valid = i[0];
      mantissa_a = 24'($urandom) | 24'h800000; exponent_a = 8'($urandom);
    end
    @(negedge clk); start_valid = 1'b0;
    chk("hold_stable", {hq, hs, he, hd}, {quotient, sticky, exponent_diff, div_by_zero});
    chk("hold_ready_valid", {30'd0, start_ready, result_valid}, 32'd1);
    result_ready = 1'b1;
    @(posedge clk); #1 result_ready = 1'b0;
    chk("hold_release", {30'd0, start_ready, result_valid}, 32'd2);

    // Reset in the middle of DIVIDE discards the operation
    @(negedge clk);
    mantissa_a = 24'h900000; mantissa_b = 24'hA00000; start_valid = 1'b1;
    @(posedge clk); #1 start_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {quotient, sticky, div_by_zero, result_valid, busy, start_ready},
        {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("midrst_expdiff", {22'd0, exponent_diff}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    n = 0;
    repeat (30) begin @(posedge clk); #1; if (result_valid) n++; end
    chk("midrst_no_result", n, 32'd0);
    do_op(vecs[1], "post_rst", w);

    // Back-to-back with start_valid held and result_ready tied high
    result_ready = 1'b1;
    begin
      vec_t cur;
      cur = model(8'd10, 8'd20, 24'hD00000, 24'hB00000);
      exponent_a = cur.ea; exponent_b = cur.eb; mantissa_a = cur.ma; mantissa_b = cur.mb;
      start_valid = 1'b1;
      accepts = 0; last_acc = -1; cyc = 0; chg = 1'b0;
      while ((accepts < 4 || sb.size() != 0) && cyc < 400) begin
        @(negedge clk);
        if (result_valid) compare_result($sformatf("b2b%0d", accepts));
        if (start_valid && start_ready) begin
          if (accepts < 4) begin
            sb.push_back(cur);
            if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 32'd28);
            last_acc = cyc;
            chg = 1'b1;
          end
          accepts++;
        end
        @(posedge clk); #1;
        cyc++;
        if (chg) begin
          chg = 1'b0;
          cur = model(8'($urandom), 8'($urandom), {1'b1, 23'($urandom)}, {1'b1, 23'($urandom)});
          exponent_a = cur.ea; exponent_b = cur.eb; mantissa_a = cur.ma; mantissa_b = cur.mb;
          if (accepts >= 4) start_valid = 1'b0;
        end
      end
      chk("b2b_done", {31'd0, cyc < 400}, 32'd1);
      start_valid = 1'b0;
      result_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculation_unit_divider_core.md
CALCULATION_UNIT_DIVIDER_CORE -- requirements
Module: calculation_unit_divider_core

Interface
REQ-001 Parameters: none; all widths fixed (float32 datapath).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start_valid  input  1  operand set presented.
REQ-006 start_ready  output  1  block accepts operands; high only in IDLE.
REQ-007 exponent_a  input  8  dividend exponent, unbiased, two's complement.
REQ-008 exponent_b  input  8  divisor exponent, unbiased, two's complement.
REQ-009 mantissa_a  input  24  dividend mantissa, hidden bit at [23].
REQ-010 mantissa_b  input  24  divisor mantissa, hidden bit at [23].
REQ-011 result_valid  output  1  result registers hold a completed quotient.
REQ-012 result_ready  input  1  downstream consumes result.
REQ-013 quotient  output  26  quotient, [25] weight 2^0, [0] weight 2^-25.
REQ-014 sticky  output  1  final partial remainder nonzero.
REQ-015 exponent_diff  output  10  sign-extended exponent_a minus sign-extended exponent_b.
REQ-016 div_by_zero  output  1  mantissa_b was zero.
REQ-017 busy  output  1  high in DIVIDE or DONE.

Function
REQ-018 The block SHALL implement a three-state machine: IDLE, DIVIDE, DONE.
REQ-019 IDLE: start_valid && start_ready SHALL capture operands, go to DIVIDE, and clear the 5-bit iteration counter.
REQ-020 Capture SHALL register exponent_diff = {{2{a[7]}},a} - {{2{b[7]}},b}, modulo 2^10; range -255..+255, never wraps.
REQ-021 Capture SHALL load a 25-bit partial remainder with {1'b0, mantissa_a}, a 24-bit divisor register, and clear quotient.
REQ-022 DIVIDE SHALL perform one restoring step per cycle: if remainder >= divisor, shift 1 into quotient LSB and subtract; else shift 0; then shift remainder left by 1.
REQ-023 DIVIDE SHALL run exactly 26 cycles, counter 0..25; on the counter-25 step, go to DONE.
REQ-024 result_valid SHALL go high exactly 26 clock edges after the accepting edge.
REQ-025 On entering DONE, sticky SHALL equal OR-reduction of the final remainder.
REQ-026 If mantissa_b == 0 at capture, div_by_zero SHALL be set, quotient forced to 26'h3FFFFFF, sticky 1, with the same 26-cycle latency.
REQ-027 DONE: quotient, sticky, exponent_diff, div_by_zero SHALL hold stable while result_ready is low, with no timeout.
REQ-028 DONE with result_ready high SHALL return to IDLE next edge and deassert result_valid.
REQ-029 start_valid SHALL be ignored outside IDLE; no operand capture while busy.
REQ-030 Throughput SHALL be one operation per 28 cycles minimum: accept, 26 steps, one DONE handshake.
REQ-031 Outputs SHALL be registered; no combinational path from inputs to outputs except start_ready from state.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE, start_ready 1, result_valid 0, busy 0, quotient 0, sticky 0, exponent_diff 0, div_by_zero 0, counter 0.
REQ-033 Reset asserted mid-DIVIDE or in DONE SHALL discard the operation; no result is ever emitted for it.
REQ-034 The first operand accept SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-035 ma=24'h800000, mb=24'h800000, ea=8'd3, eb=8'd1 -> quotient=26'h2000000, sticky=0, exponent_diff=10'd2, result_valid 26 edges after accept.
REQ-036 ma=24'h800000, mb=24'hC00000, ea=8'h80, eb=8'h7F -> quotient=26'h1555555, sticky=1, exponent_diff=10'h301.
REQ-037 Hold result_ready=0 for 10 cycles in DONE -> outputs unchanged, start_ready=0, start_valid pulses ignored; release -> IDLE next edge.
REQ-038 Assert reset_n=0 at iteration 10 -> all outputs at reset values immediately; after release, a new accept completes normally.
REQ-039 mb=24'h000000, ma=24'hA00000 -> div_by_zero=1, quotient=26'h3FFFFFF, sticky=1 after 26 cycles.
REQ-040 Back-to-back ops with result_ready tied high and start_valid held -> accepts spaced exactly 28 cycles apart, each result matching a reference model.
